// File: rtl/inst_axi_bridge.sv
// Instruction-side SRAM-like to AXI read bridge: one single-beat read in flight at a time.
// Write-related request fields are ignored; every accepted request becomes an AXI read.
module inst_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_rdata;
  logic        w_rbeatOurs;
  logic        w_unused;

  assign w_rbeatOurs = rvalid && (rid == AXI_ID);
  assign w_unused    = &{1'b0, inst_sram_wr, inst_sram_wen, inst_sram_wdata, rresp, rlast};

  // A beat with a foreign ID is still handshaken (rready high) but simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'h0;
      r_size  <= 2'b00;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inst_sram_en) begin
            r_addr  <= inst_sram_addr;
            r_size  <= inst_sram_size;
            r_state <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) r_state <= ST_R;
        end
        ST_R: begin
          if (w_rbeatOurs) begin
            r_rdata <= rdata;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are masked while reset is asserted so nothing leaks out mid-reset.
  assign inst_sram_addr_ok = !reset && (r_state == ST_IDLE) && inst_sram_en;
  assign inst_sram_data_ok = !reset && (r_state == ST_DONE);
  assign inst_sram_rdata   = r_rdata;

  assign arvalid = !reset && (r_state == ST_AR);
  assign rready  = !reset && (r_state == ST_R);
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

endmodule
